// File: rtl/medfilt_out_fifo_if.sv
// Show-ahead valid/ready read port carrying filtered median samples to the consumer.
interface medfilt_out_fifo_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/medfilt_out_fifo.sv
// Capture stage behind the 3-tap median filter: skips pipeline warm-up samples,
// buffers valid medians in a FIFO and reports samples lost to a full buffer.
module medfilt_out_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int FILL   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_W-1:0]        din,
  medfilt_out_fifo_if.master       rd,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     warm,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     ovf_clr
);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int WCW = (FILL < 1) ? 1 : $clog2(FILL + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [WCW-1:0]    wcnt;
  logic              push, pop, full, wr, drop;

  assign warm     = (wcnt == WCW'(FILL));
  assign full     = (level == LW'(DEPTH));
  assign rd.valid = (level != '0);
  assign rd.data  = mem[rptr];
  assign push     = en & warm;
  assign pop      = rd.valid & rd.ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign wr       = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      // Dropping en re-arms the warm-up; queued samples stay readable.
      if (!en)        wcnt <= '0;
      else if (!warm) wcnt <= wcnt + 1'b1;

      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;

      case ({wr, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
        overflow <= 1'b1;
        if (ovf_clr)               drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_medfilt_out_fifo.sv
// Scoreboard bench for medfilt_out_fifo: a queue model tracks accepted samples, warm-up and drop accounting.
module tb_medfilt_out_fifo;
  localparam int DW = 8, DEPTH = 16, FILL = 4;

  logic          clk = 1'b0;
  logic          rst, en, ovf_clr;
  logic [DW-1:0] din;
  logic [4:0]    level;
  logic          warm, overflow;
  logic [7:0]    drop_cnt;

  medfilt_out_fifo_if #(.DATA_W(DW)) rd_if ();

  medfilt_out_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .rd(rd_if.master),
    .level(level), .warm(warm), .overflow(overflow), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  logic [DW-1:0] sb [$];
  int            m_wcnt;
  bit            m_ovf;
  int            m_drop;

  // Per-cycle results of the last tick, for the scenario tasks to check.
  bit            t_pop, t_gotv;
  logic [DW-1:0] t_exp, t_got;

  task automatic do_rst(input logic e);
    rst = 1'b1; en = e; din = 8'hEE; rd_if.ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete(); m_wcnt = 0; m_ovf = 0; m_drop = 0;
  endtask

  // Drives one cycle; inputs applied 1ns after the edge, so outputs seen here are pre-edge state.
  task automatic tick(input logic e, input logic [DW-1:0] d, input logic rr, input logic clr);
    bit m_push, m_full, m_dropped;
    en = e; din = d; rd_if.ready = rr; ovf_clr = clr;
    t_gotv = rd_if.valid; t_got = rd_if.data;
    t_pop  = (sb.size() != 0) && rr;
    m_push = e && (m_wcnt == FILL);
    m_full = (sb.size() == DEPTH);
    m_dropped = m_push && m_full && !t_pop;
    if (t_pop) t_exp = sb.pop_front();
    if (m_dropped) begin
      m_ovf  = 1;
      m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else begin
      if (m_push) sb.push_back(d);
      if (clr) begin m_ovf = 0; m_drop = 0; end
    end
    m_wcnt = !e ? 0 : ((m_wcnt < FILL) ? m_wcnt + 1 : m_wcnt);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    do_rst(1'b0);
    n_chk++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_chk++; if (rd_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rd_if.valid); end
    n_chk++; if (warm !== 1'b0) begin n_fail++; $display("FAIL reset_warm got %b exp 0", warm); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
  endtask

  // Warm-up discard then overfill with rd_ready low, then drain.
  task automatic test_warmup_overflow;
    for (int i = 0; i < FILL; i++) begin
      n_chk++; if (warm !== 1'b0) begin n_fail++; $display("FAIL warm_early cyc %0d got %b exp 0", i, warm); end
      tick(1'b1, DW'(i), 1'b0, 1'b0);
    end
    n_chk++; if (warm !== 1'b1) begin n_fail++; $display("FAIL warm_rise got %b exp 1", warm); end
    n_chk++; if (rd_if.valid !== 1'b0) begin n_fail++; $display("FAIL warm_valid_pre got %b exp 0", rd_if.valid); end
    tick(1'b1, 8'd4, 1'b0, 1'b0);
    n_chk++; if (rd_if.valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b exp 1", rd_if.valid); end
    n_chk++; if (rd_if.data !== 8'd4) begin n_fail++; $display("FAIL first_data got %0d exp 4", rd_if.data); end
    for (int i = 5; i < 24; i++) tick(1'b1, DW'(i), 1'b0, 1'b0);
    n_chk++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level got %0d exp 16", level); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_chk++; if (drop_cnt !== 8'd4) begin n_fail++; $display("FAIL ovf_drop got %0d exp 4", drop_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      n_chk++;
      if (t_gotv !== 1'b1 || t_got !== t_exp || t_exp !== DW'(i + 4)) begin
        n_fail++; $display("FAIL drain_data idx %0d got %0d/v%b exp %0d", i, t_got, t_gotv, i + 4);
      end
    end
    n_chk++; if (rd_if.valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", rd_if.valid); end
  endtask

  // Fill, then simultaneous push/pop at full, then drop/clear collision.
  task automatic test_full_stream;
    logic [7:0] d0;
    do_rst(1'b0);
    for (int i = 0; i < FILL + DEPTH; i++) tick(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    n_chk++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level got %0d exp 16", level); end
    d0 = drop_cnt;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, DW'(8'h80 + i), 1'b1, 1'b0);
      n_chk++;
      if (t_got !== t_exp || level !== 5'd16) begin
        n_fail++; $display("FAIL full_stream cyc %0d data %0d exp %0d level %0d exp 16", i, t_got, t_exp, level);
      end
    end
    n_chk++; if (drop_cnt !== d0) begin n_fail++; $display("FAIL full_stream_drop got %0d exp %0d", drop_cnt, d0); end
    for (int i = 0; i < 3; i++) tick(1'b1, 8'hA0, 1'b0, 1'b0);
    n_chk++; if (drop_cnt !== 8'd3 || overflow !== 1'b1) begin n_fail++; $display("FAIL drop3 got %0d/%b exp 3/1", drop_cnt, overflow); end
    tick(1'b1, 8'hA1, 1'b0, 1'b1);
    n_chk++; if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_drop got %0d/%b exp 1/1", drop_cnt, overflow); end
    tick(1'b0, 8'hA2, 1'b0, 1'b1);
    n_chk++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL clr got %0d/%b exp 0/0", drop_cnt, overflow); end
  endtask

  // Random consumer backpressure across several pointer wraps.
  task automatic test_random;
    do_rst(1'b0);
    for (int i = 0; i < FILL + 40; i++) begin
      tick(1'b1, DW'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 1'b0);
      n_chk++;
      if (level !== sb.size() || (t_pop && (t_gotv !== 1'b1 || t_got !== t_exp))) begin
        n_fail++; $display("FAIL rand cyc %0d level %0d exp %0d data %0d exp %0d", i, level, sb.size(), t_got, t_exp);
      end
    end
    n_chk++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL rand_drop got %0d exp %0d", drop_cnt, m_drop); end
    while (sb.size() != 0) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      n_chk++; if (t_got !== t_exp) begin n_fail++; $display("FAIL rand_drain got %0d exp %0d", t_got, t_exp); end
    end
  endtask

  task automatic test_rst_midstream;
    do_rst(1'b0);
    for (int i = 0; i < FILL + 7; i++) tick(1'b1, DW'(i), 1'b0, 1'b0);
    n_chk++; if (level !== 5'd7) begin n_fail++; $display("FAIL mid_level got %0d exp 7", level); end
    do_rst(1'b1);
    n_chk++; if (level !== 5'd0 || rd_if.valid !== 1'b0 || warm !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst level %0d valid %b warm %b exp 0/0/0", level, rd_if.valid, warm);
    end
    for (int i = 0; i < FILL; i++) tick(1'b1, DW'(8'h64 + i), 1'b0, 1'b0);
    n_chk++; if (rd_if.valid !== 1'b0) begin n_fail++; $display("FAIL rewarm_discard got %b exp 0", rd_if.valid); end
    tick(1'b1, 8'h68, 1'b0, 1'b0);
    n_chk++; if (rd_if.data !== 8'h68 || level !== 5'd1) begin n_fail++; $display("FAIL rewarm_first got %0d level %0d exp 104/1", rd_if.data, level); end
  endtask

  task automatic test_en_gap;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, DW'(8'h70 + i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'hFF, 1'b1, 1'b0);
      n_chk++; if (t_got !== t_exp) begin n_fail++; $display("FAIL gap_drain got %0d exp %0d", t_got, t_exp); end
    end
    for (int i = 0; i < FILL; i++) tick(1'b1, DW'(8'hC8 + i), 1'b0, 1'b0);
    n_chk++; if (level !== 5'd1 || rd_if.data !== 8'h72) begin n_fail++; $display("FAIL gap_discard level %0d data %0d exp 1/114", level, rd_if.data); end
    tick(1'b1, 8'hCC, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    n_chk++; if (t_got !== 8'hCC || t_got !== t_exp) begin n_fail++; $display("FAIL gap_resume got %0d exp 204", t_got); end
    n_chk++; if (rd_if.valid !== 1'b0) begin n_fail++; $display("FAIL gap_empty got %b exp 0", rd_if.valid); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = '0; ovf_clr = 1'b0; rd_if.ready = 1'b0;
    test_reset();
    test_warmup_overflow();
    test_full_stream();
    test_random();
    test_rst_midstream();
    test_en_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
